// File: rtl/packet_ram_reader.sv
// rtl/packet_ram_reader.sv - replays a packet stored in RAM as a framed stream
//
// Purpose:
//   Accepts a (addr, len, ctl) command, reads ceil(len/DAT_BYTS) consecutive
//   RAM words (address wraps modulo RAM_DEPTH) and emits them as one stream
//   packet with sop/eop/mod framing. Read data lands in a small skid FIFO so
//   that stream backpressure never drops a beat; reads are only issued while
//   there is guaranteed room for their data.
//
// Optional feature macro: PACKET_RAM_READER_ERR_EN
//   When defined, err is raised on the eop beat if the packet wraps past the
//   end of the RAM (addr+beats > RAM_DEPTH) or len exceeds the RAM size.
//   When undefined, err is constant 0 and wrapping is silent.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_cmd_val/o_cmd_rdy   command handshake
//   i_cmd_addr            first RAM word of the packet
//   i_cmd_len             packet length in bytes
//   i_cmd_ctl             ctl sideband copied onto every beat
//   o_busy                packet in progress
//   o_ram_a/en/re/we/d    RAM read port (we and d tied 0)
//   i_ram_q               RAM read data, valid RAM_LAT cycles after en
//   o_axi_val/sop/eop/err/ctl/dat/mod, i_axi_rdy   output stream

module packet_ram_reader #(
  parameter int DAT_BYTS  = 64,
  parameter int RAM_DEPTH = 128,
  parameter int RAM_LAT   = 2,
  parameter int LEN_BITS  = 16,
  parameter int CTL_BITS  = 8,
  localparam int AW = $clog2(RAM_DEPTH),
  localparam int DW = DAT_BYTS * 8,
  localparam int MW = $clog2(DAT_BYTS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cmd_val,
  output logic                o_cmd_rdy,
  input  logic [AW-1:0]       i_cmd_addr,
  input  logic [LEN_BITS-1:0] i_cmd_len,
  input  logic [CTL_BITS-1:0] i_cmd_ctl,
  output logic                o_busy,
  output logic [AW-1:0]       o_ram_a,
  output logic                o_ram_en,
  output logic                o_ram_re,
  output logic                o_ram_we,
  output logic [DW-1:0]       o_ram_d,
  input  logic [DW-1:0]       i_ram_q,
  output logic                o_axi_val,
  output logic                o_axi_sop,
  output logic                o_axi_eop,
  output logic                o_axi_err,
  output logic [CTL_BITS-1:0] o_axi_ctl,
  output logic [DW-1:0]       o_axi_dat,
  output logic [MW-1:0]       o_axi_mod,
  input  logic                i_axi_rdy
);

  // FIFO holds every read that can be in flight, so it never overflows.
  localparam int FD   = RAM_LAT + 1;
  localparam int PW   = (FD > 1) ? $clog2(FD) : 1;
  localparam int CNTW = $clog2(FD + 1);
  localparam int SW   = CNTW + 2;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_t;

  state_t state_q, state_d;

  logic [AW-1:0]       addr_q;
  logic [LEN_BITS-1:0] beats_q;
  logic [LEN_BITS-1:0] issue_left_q;
  logic [LEN_BITS-1:0] out_idx_q;
  logic [MW-1:0]       mod_q;
  logic [CTL_BITS-1:0] ctl_q;
  logic [RAM_LAT-1:0]  vld_q;

  logic [DW-1:0]       fifo_mem [FD];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]     fifo_cnt_q;

  logic                cmd_fire;
  logic [LEN_BITS-1:0] cmd_beats;
  logic                issue;
  logic                pop;
  logic                fifo_wr;
  logic                last_beat;
  logic                credit_ok;
  logic [CNTW-1:0]     outst;

  assign cmd_fire  = i_cmd_val && o_cmd_rdy;
  // Round the byte length up to whole beats.
  assign cmd_beats = (i_cmd_len >> MW) + {{(LEN_BITS-1){1'b0}}, |i_cmd_len[MW-1:0]};
  assign fifo_wr   = vld_q[RAM_LAT-1];
  assign o_axi_val = (fifo_cnt_q != '0);
  assign pop       = o_axi_val && i_axi_rdy;
  assign last_beat = (out_idx_q == beats_q - 1'b1);

  // Reads still travelling through the RAM pipeline.
  always_comb begin
    outst = '0;
    for (int i = 0; i < RAM_LAT; i++) begin
      outst = outst + CNTW'(vld_q[i]);
    end
  end

  // A slot freed by this cycle's pop may be reused by this cycle's read,
  // which keeps full throughput when rdy stays high.
  assign credit_ok = (SW'(fifo_cnt_q) + SW'(outst)) < (SW'(FD) + SW'(pop));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // Zero-length commands are consumed without leaving IDLE.
        if (cmd_fire && (i_cmd_len != '0)) state_d = ST_READ;
      end
      ST_READ: begin
        if (issue && (issue_left_q == {{(LEN_BITS-1){1'b0}}, 1'b1})) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && last_beat) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    o_cmd_rdy = 1'b0;
    o_busy    = 1'b0;
    issue     = 1'b0;
    case (state_q)
      ST_IDLE:  o_cmd_rdy = !i_rst;
      ST_READ: begin
        o_busy = 1'b1;
        issue  = (issue_left_q != '0) && credit_ok;
      end
      ST_DRAIN: o_busy = 1'b1;
      default: ;
    endcase
  end

  // ---------------- command / read datapath ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q       <= '0;
      beats_q      <= '0;
      issue_left_q <= '0;
      out_idx_q    <= '0;
      mod_q        <= '0;
      ctl_q        <= '0;
      vld_q        <= '0;
    end else begin
      if (cmd_fire) begin
        addr_q       <= i_cmd_addr;
        beats_q      <= cmd_beats;
        issue_left_q <= cmd_beats;
        out_idx_q    <= '0;
        mod_q        <= i_cmd_len[MW-1:0];
        ctl_q        <= i_cmd_ctl;
      end else begin
        if (issue) begin
          addr_q       <= (addr_q == AW'(RAM_DEPTH - 1)) ? '0 : addr_q + 1'b1;
          issue_left_q <= issue_left_q - 1'b1;
        end
        if (pop) begin
          out_idx_q <= out_idx_q + 1'b1;
        end
      end
      for (int i = RAM_LAT - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
      end
      vld_q[0] <= issue;
    end
  end

  // ---------------- skid FIFO ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr_q <= (wr_ptr_q == PW'(FD - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(FD - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      fifo_cnt_q <= fifo_cnt_q + CNTW'(fifo_wr) - CNTW'(pop);
    end
  end

  // Payload storage needs no reset; occupancy lives in the counters above.
  always_ff @(posedge i_clk) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr_q] <= i_ram_q;
    end
  end

  // ---------------- RAM port ----------------
  assign o_ram_en = issue;
  assign o_ram_re = issue;
  assign o_ram_a  = issue ? addr_q : '0;
  assign o_ram_we = 1'b0;
  assign o_ram_d  = '0;

  // ---------------- stream framing ----------------
  assign o_axi_dat = o_axi_val ? fifo_mem[rd_ptr_q] : '0;
  assign o_axi_ctl = o_axi_val ? ctl_q : '0;
  assign o_axi_sop = o_axi_val && (out_idx_q == '0);
  assign o_axi_eop = o_axi_val && last_beat;
  assign o_axi_mod = o_axi_eop ? mod_q : '0;

`ifdef PACKET_RAM_READER_ERR_EN
  localparam int EW = LEN_BITS + AW + 1;

  logic err_q;
  logic err_hit;

  assign err_hit = ((EW'(i_cmd_addr) + EW'(cmd_beats)) > EW'(RAM_DEPTH)) ||
                   (EW'(i_cmd_len) > EW'(RAM_DEPTH * DAT_BYTS));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q <= 1'b0;
    end else if (cmd_fire) begin
      err_q <= err_hit;
    end
  end

  assign o_axi_err = o_axi_eop && err_q;
`else
  assign o_axi_err = 1'b0;
`endif

endmodule

// File: tb/tb_packet_ram_reader.sv
// tb/tb_packet_ram_reader.sv - scoreboard bench for packet_ram_reader

module tb_packet_ram_reader;

  localparam int DAT_BYTS  = 64;
  localparam int RAM_DEPTH = 128;
  localparam int RAM_LAT   = 2;
  localparam int LEN_BITS  = 16;
  localparam int CTL_BITS  = 8;
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int DW = DAT_BYTS * 8;
  localparam int MW = $clog2(DAT_BYTS);
  localparam int FD = RAM_LAT + 1;

  typedef struct {
    logic [DW-1:0]       dat;
    logic                sop;
    logic                eop;
    logic                err;
    logic [MW-1:0]       mod;
    logic [CTL_BITS-1:0] ctl;
  } beat_t;

  logic                clk;
  logic                rst;
  logic                cmd_val;
  logic                cmd_rdy;
  logic [AW-1:0]       cmd_addr;
  logic [LEN_BITS-1:0] cmd_len;
  logic [CTL_BITS-1:0] cmd_ctl;
  logic                busy;
  logic [AW-1:0]       ram_a;
  logic                ram_en, ram_re, ram_we;
  logic [DW-1:0]       ram_d, ram_q;
  logic                axi_val, axi_sop, axi_eop, axi_err, axi_rdy;
  logic [CTL_BITS-1:0] axi_ctl;
  logic [DW-1:0]       axi_dat;
  logic [MW-1:0]       axi_mod;

  int    total = 0;
  int    bad   = 0;
  beat_t exp_q[$];
  int    exp_a_q[$];
  bit    pkt_active = 0;
  bit    rnd_mode   = 0;
  bit    hold_v     = 0;
  logic [DW-1:0] hold_dat;
  int    issued = 0;
  int    popped = 0;
  int    n_xfer = 0;

  packet_ram_reader #(
    .DAT_BYTS(DAT_BYTS), .RAM_DEPTH(RAM_DEPTH), .RAM_LAT(RAM_LAT),
    .LEN_BITS(LEN_BITS), .CTL_BITS(CTL_BITS)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_val(cmd_val), .o_cmd_rdy(cmd_rdy), .i_cmd_addr(cmd_addr),
    .i_cmd_len(cmd_len), .i_cmd_ctl(cmd_ctl), .o_busy(busy),
    .o_ram_a(ram_a), .o_ram_en(ram_en), .o_ram_re(ram_re), .o_ram_we(ram_we),
    .o_ram_d(ram_d), .i_ram_q(ram_q),
    .o_axi_val(axi_val), .o_axi_sop(axi_sop), .o_axi_eop(axi_eop),
    .o_axi_err(axi_err), .o_axi_ctl(axi_ctl), .o_axi_dat(axi_dat),
    .o_axi_mod(axi_mod), .i_axi_rdy(axi_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(input int i);
    logic [DW-1:0] w;
    for (int b = 0; b < DAT_BYTS; b++) w[b*8 +: 8] = 8'((i * 37 + b * 3 + 1) & 255);
    return w;
  endfunction

  // RAM model: data for a read appears RAM_LAT cycles after en.
  logic [DW-1:0] ram [RAM_DEPTH];
  logic [DW-1:0] q_pipe [RAM_LAT];
  initial for (int i = 0; i < RAM_DEPTH; i++) ram[i] = word_of(i);
  always @(posedge clk) begin
    q_pipe[0] <= ram_en ? ram[ram_a] : '0;
    for (int i = 1; i < RAM_LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign ram_q = q_pipe[RAM_LAT-1];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    axi_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      axi_rdy = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor and scoreboard, sampling mid-cycle.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("cmd_rdy", cmd_rdy, !pkt_active);
        chk("busy", busy, pkt_active);
        chk("ram_we_d", ram_we | (|ram_d), 0);
        chk("ram_en_re", ram_en, ram_re);
        chk("credit", (issued - popped) <= FD, 1);
        if (hold_v) begin
          chk("hold_val", axi_val, 1);
          chk("hold_dat", axi_dat, hold_dat);
        end
        if (ram_en) begin
          if (exp_a_q.size() == 0) chk("ram_extra_en", 1, 0);
          else chk("ram_addr", ram_a, exp_a_q.pop_front());
          issued++;
        end
        if (axi_val) begin
          if (exp_q.size() == 0) chk("axi_extra", 1, 0);
          else if (axi_rdy) begin
            e = exp_q.pop_front();
            chk("dat", axi_dat, e.dat);
            chk("sop", axi_sop, e.sop);
            chk("eop", axi_eop, e.eop);
            chk("mod", axi_mod, e.mod);
            chk("ctl", axi_ctl, e.ctl);
            chk("err", axi_err, e.err);
            popped++;
            n_xfer++;
            if (e.eop) pkt_active = 0;
          end
        end
        hold_v   = axi_val && !axi_rdy;
        hold_dat = axi_dat;
      end
    end
  end

  task automatic send_cmd(input int addr, input int len, input int ctl, input bit check_lat);
    bit    got;
    int    beats, n;
    bit    errc;
    beat_t b;
    @(posedge clk);
    #1;
    cmd_val  = 1'b1;
    cmd_addr = AW'(addr);
    cmd_len  = LEN_BITS'(len);
    cmd_ctl  = CTL_BITS'(ctl);
    got = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_rdy) begin got = 1; break; end
    end
    chk("cmd_accept", got, 1);
    if (!got) begin cmd_val = 1'b0; return; end
    beats = (len + DAT_BYTS - 1) / DAT_BYTS;
`ifdef PACKET_RAM_READER_ERR_EN
    errc = (addr + beats > RAM_DEPTH) || (len > RAM_DEPTH * DAT_BYTS);
`else
    errc = 0;
`endif
    for (int i = 0; i < beats; i++) begin
      b.dat = word_of((addr + i) % RAM_DEPTH);
      b.sop = (i == 0);
      b.eop = (i == beats - 1);
      b.mod = b.eop ? MW'(len % DAT_BYTS) : '0;
      b.ctl = CTL_BITS'(ctl);
      b.err = b.eop && errc;
      exp_q.push_back(b);
      exp_a_q.push_back((addr + i) % RAM_DEPTH);
    end
    @(posedge clk);
    #1;
    cmd_val = 1'b0;
    if (len != 0) pkt_active = 1;
    if (check_lat) begin
      n = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (axi_val) break;
        n++;
      end
      chk("first_val_lat", n, RAM_LAT + 1);
    end
  endtask

  task automatic wait_done();
    bit done = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !pkt_active) begin done = 1; break; end
    end
    chk("drain_timeout", done, 1);
  endtask

  initial begin
    int base;
    bit reached;
    rst      = 1'b1;
    cmd_val  = 1'b0;
    cmd_addr = '0;
    cmd_len  = '0;
    cmd_ctl  = '0;
    #2;
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_val", axi_val, 0);
    chk("rst_en", ram_en, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // single full beat with latency check
    send_cmd(0, 64, 8'h11, 1);
    wait_done();
    // four beats, partial last
    send_cmd(5, 200, 8'h22, 0);
    wait_done();
    // backpressure
    rnd_mode = 1;
    send_cmd(5, 200, 8'h33, 0);
    wait_done();
    send_cmd(40, 1000, 8'h44, 0);
    wait_done();
    rnd_mode = 0;
    #20;
    // wrap past the top of the RAM
    send_cmd(126, 256, 8'h5a, 0);
    wait_done();
    // zero length then a normal packet
    send_cmd(50, 0, 8'h77, 0);
    repeat (6) @(posedge clk);
    send_cmd(60, 130, 8'h78, 1);
    wait_done();

    // reset in the middle of a four-beat packet
    base = n_xfer;
    send_cmd(20, 256, 8'h55, 0);
    reached = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      if (n_xfer >= base + 2) begin reached = 1; break; end
    end
    chk("mid_pkt_reached", reached, 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_ctl_outs", {axi_val, axi_sop, axi_eop, axi_err, axi_mod, axi_ctl,
                            ram_en, ram_re, ram_we, ram_a, cmd_rdy, busy}, 0);
    chk("midrst_dat", axi_dat, 0);
    exp_q.delete();
    exp_a_q.delete();
    pkt_active = 0;
    hold_v     = 0;
    issued     = 0;
    popped     = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    send_cmd(10, 64, 8'h66, 1);
    wait_done();
    repeat (8) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/packet_ram_reader.md
Name: packet_ram_reader

Overview:
- Reads a packet previously written into a RAM and replays it as an AXI-stream packet with sop/eop/mod framing.
- Initiator side of the if_ram protocol (drives the source modport toward the RAM); source side of if_axi_stream.
- Counterpart to the stream-to-RAM writers; used to drain stored blocks/headers back into stream pipelines.

Parameters:
- DAT_BYTS, 64, stream bytes per beat; RAM_WIDTH must equal DAT_BYTS*8.
- RAM_DEPTH, 128, RAM words; address width $clog2(RAM_DEPTH).
- RAM_LAT, 2, cycles from re/en asserted to q valid (1..4).
- LEN_BITS, 16, width of the byte-length command field.
- CTL_BITS, 8, ctl sideband width passed through to every beat.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_cmd_val  in  1  command valid
- o_cmd_rdy  out  1  command accepted when val&&rdy
- i_cmd_addr  in  $clog2(RAM_DEPTH)  first RAM word of packet
- i_cmd_len  in  LEN_BITS  packet length in bytes
- i_cmd_ctl  in  CTL_BITS  ctl value for all beats
- o_busy  out  1  packet in progress
- o_ram  if_ram.source  RAM read port (a, en, re, we, d out; q in)
- o_axi  if_axi_stream.source  output stream (val, sop, eop, err, ctl, dat, mod out; rdy in)

Behaviour:
- Reset: o_cmd_rdy=0 during reset, o_busy=0, all o_ram outputs 0, all o_axi outputs 0, skid FIFO empty, state IDLE. Outputs go to reset values immediately on i_rst.
- we and d are tied 0 at all times; en=re on every read.
- States: IDLE -> READ -> DRAIN -> IDLE.
- IDLE: o_cmd_rdy=1. On val&&rdy, latch addr, len, ctl; beats = ceil(len/DAT_BYTS); go to READ next cycle. A command with len=0 is accepted and discarded; stay in IDLE, no beat emitted.
- READ: issue one read per cycle (en=re=1, a=addr), increment addr, only while outstanding+FIFO occupancy < RAM_LAT+1. Once all beats are issued, go to DRAIN.
- DRAIN: wait until the last beat leaves o_axi, then return to IDLE. o_cmd_rdy rises the cycle after the last beat transfers.
- Read data enters a skid FIFO of depth RAM_LAT+1, tracked by a RAM_LAT-stage valid pipeline. Full stream backpressure never drops data.
- o_axi beat framing:
  - sop=1 on first beat only.
  - eop=1 on beat index beats-1.
  - mod = len % DAT_BYTS on the eop beat (0 means full beat), 0 on other beats.
  - ctl = latched ctl; err=0 (see optional feature).
- Stream rules: o_axi.val holds with stable data until rdy. Throughput is 1 beat/cycle when rdy is held high.
- Latency: first val asserts RAM_LAT+1 cycles after command acceptance.
- Address arithmetic: addr increments modulo RAM_DEPTH (wraps to 0 past RAM_DEPTH-1); width is $clog2(RAM_DEPTH).
- o_busy=1 from acceptance until the cycle after the eop transfer.
- Reset mid-packet: everything returns to reset values; in-flight RAM reads are ignored after reset deassertion.

Optional Feature:
- Macro: PACKET_RAM_READER_ERR_EN.
- Defined: at acceptance, compute addr+beats > RAM_DEPTH. If true, the packet still streams (wrapping) but err=1 on the eop beat. len > RAM_DEPTH*DAT_BYTS also sets err.
- Undefined: err is constant 0 and wrap is silent; no comparator is synthesized.

Test Plan:
- Command addr=0, len=64, DAT_BYTS=64, rdy=1 -> one beat, sop=eop=1, mod=0; val first seen at cycle RAM_LAT+1 after accept; dat=RAM[0].
- addr=5, len=200 -> 4 beats from RAM[5..8]; sop on beat 0, eop on beat 3 with mod=8; o_cmd_rdy=0 until after eop.
- len=200 with rdy toggling 1,0,0,1 pseudo-randomly -> identical beat sequence, no drop or duplicate; RAM reads pause when FIFO reaches RAM_LAT+1.
- addr=126, len=256, RAM_DEPTH=128 -> reads words 126,127,0,1. With PACKET_RAM_READER_ERR_EN, err=1 on eop; without it, err=0.
- len=0 command -> accepted, no o_axi.val, no RAM en; the next command proceeds normally.
- Assert i_rst mid-packet on beat 2 of 4 -> all outputs 0 immediately. After release, a new command addr=10, len=64 emits exactly one clean beat of RAM[10].
